// File: rtl/knn_distance_engine.sv
// knn_distance_engine: streams (distance, index) per training sample against a cached test vector.
// Define KNN_SQ_EUCLID_EN for saturating squared-Euclidean distance instead of Manhattan.
module knn_distance_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_FEATURES = 4,
  parameter int NUM_SAMPLES  = 16,
  parameter int DIST_W       = 32,
  parameter int INDEX_WIDTH  = 4,
  parameter int FEAT_W       = 2,
  parameter int SADDR_W      = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] cfg_num_samples,
  input  logic [FEAT_W-1:0]      cfg_num_features,
  output logic                   test_ren,
  output logic [FEAT_W-1:0]      test_raddr,
  input  logic [DATA_WIDTH-1:0]  test_rdata_q,
  output logic                   sample_ren,
  output logic [SADDR_W-1:0]     sample_raddr,
  input  logic [DATA_WIDTH-1:0]  sample_rdata_q,
  output logic                   dist_valid,
  output logic [DIST_W-1:0]      dist_data,
  output logic [INDEX_WIDTH-1:0] dist_index,
  input  logic                   dist_ready,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [2:0] {IDLE, LOAD_TEST, FETCH, EMIT, DONE} state_t;
  state_t state;
  logic [INDEX_WIDTH-1:0] s, s_last;
  logic [FEAT_W-1:0] f, f_last, pf;
  logic pend;
  logic [DATA_WIDTH-1:0] treg [NUM_FEATURES];
  logic [DATA_WIDTH-1:0] diff;
  logic [DIST_W-1:0] acc, term, add_t, nxt;
  logic [DIST_W:0] sum;
  logic add_v, add_l;
  assign test_raddr = f;
  always_comb begin
    diff = sample_rdata_q >= treg[pf] ? sample_rdata_q - treg[pf] : treg[pf] - sample_rdata_q;
`ifdef KNN_SQ_EUCLID_EN
    term = DIST_W'({{DATA_WIDTH{1'b0}}, diff} * {{DATA_WIDTH{1'b0}}, diff});
`else
    term = DIST_W'(diff);
`endif
    sum = {1'b0, acc} + {1'b0, add_t};
    nxt = sum[DIST_W] ? '1 : sum[DIST_W-1:0];
  end
`ifdef KNN_SQ_EUCLID_EN
  // the multiplier output is registered, costing one extra cycle per sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_v <= 1'b0;
      add_l <= 1'b0;
      add_t <= '0;
    end else begin
      add_v <= pend && state == FETCH;
      add_l <= pf == f_last;
      add_t <= term;
    end
  end
`else
  assign add_v = pend && state == FETCH;
  assign add_l = pf == f_last;
  assign add_t = term;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      s            <= '0;
      s_last       <= '0;
      f            <= '0;
      f_last       <= '0;
      pf           <= '0;
      pend         <= 1'b0;
      acc          <= '0;
      test_ren     <= 1'b0;
      sample_ren   <= 1'b0;
      sample_raddr <= '0;
      dist_valid   <= 1'b0;
      dist_data    <= '0;
      dist_index   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < NUM_FEATURES; i++) treg[i] <= '0;
    end else begin
      // a read issued last cycle returns its word this cycle
      pend <= test_ren | sample_ren;
      pf   <= f;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= LOAD_TEST;
          busy     <= 1'b1;
          s        <= '0;
          f        <= '0;
          test_ren <= 1'b1;
          s_last   <= cfg_num_samples == '0 ? INDEX_WIDTH'(NUM_SAMPLES - 1) : cfg_num_samples - INDEX_WIDTH'(1);
          f_last   <= cfg_num_features == '0 ? FEAT_W'(NUM_FEATURES - 1) : cfg_num_features - FEAT_W'(1);
        end
        LOAD_TEST: begin
          if (test_ren) begin
            if (f == f_last) test_ren <= 1'b0;
            else f <= f + FEAT_W'(1);
          end
          if (pend) treg[pf] <= test_rdata_q;
          if (pend && pf == f_last) begin
            state        <= FETCH;
            f            <= '0;
            sample_ren   <= 1'b1;
            sample_raddr <= '0;
            acc          <= '0;
          end
        end
        FETCH: begin
          if (sample_ren) begin
            if (f == f_last) sample_ren <= 1'b0;
            else begin
              f            <= f + FEAT_W'(1);
              sample_raddr <= sample_raddr + SADDR_W'(1);
            end
          end
          if (add_v) begin
            if (add_l) begin
              dist_data  <= nxt;
              dist_index <= s;
              dist_valid <= 1'b1;
              acc        <= '0;
              state      <= EMIT;
            end else acc <= nxt;
          end
        end
        EMIT: if (dist_ready) begin
          dist_valid <= 1'b0;
          if (s == s_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            s            <= s + INDEX_WIDTH'(1);
            f            <= '0;
            sample_ren   <= 1'b1;
            sample_raddr <= SADDR_W'((s + 1) * NUM_FEATURES);
            state        <= FETCH;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
